lsu_dm_master: RTL and testbench
================================

Name: lsu_dm_master

Overview:
Initiator-side load/store unit that drives the word-wide data memory (DM) on behalf of the pipeline MEM stage.
- Accepts one byte/half/word load or store per valid/ready handshake.
- Checks alignment and range.
- Performs read-modify-write for sub-word stores, since DM writes only whole words.
- Returns extracted, sign/zero-extended load data on a one-cycle response pulse.

Parameters:
DM_WORDS, 1024, DM depth in 32-bit words; byte addresses >= DM_WORDS*4 are out of range.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request (IDLE only)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load result (ignored for stores/word)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_pc  in  32  PC of issuing instruction, forwarded to DM for write logging
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load result (0 for stores/errors)
rsp_err  out  1  misaligned, illegal size or out of range; valid with rsp_valid
dm_addr  out  32  word-aligned byte address to DM
dm_wd  out  32  write data to DM
dm_we  out  1  DM write enable (DM commits on rising clk)
dm_pc  out  32  PC to DM
dm_rd  in  32  DM combinational read data for dm_addr

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; all outputs 0, including req_ready (forced 0 while reset low).
  - The request register is cleared.
  - An in-flight op is aborted; no DM write occurs once reset is low before the WRITE edge.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1. A handshake (req_valid & req_ready) at a rising edge registers addr/size/signed/wdata/pc.
  - Next state on that handshake:
    - error: RESP with err=1
    - load: LOAD
    - word store: WRITE
    - byte/half store: RMW_RD
- Error conditions:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr >= DM_WORDS*4.
  - On any error: no DM access, dm_we stays 0.
- dm_addr = {addr[31:2],2'b00} in LOAD/RMW_RD/WRITE; dm_pc = registered pc in WRITE; both 0 in IDLE/RESP.
- LOAD (1 cycle):
  - dm_rd is captured at the ending edge.
  - Byte lane addr[1:0], half lane addr[1] (little-endian).
  - Extended to 32 bits per req_signed.
  - Next state: RESP.
- RMW_RD (1 cycle):
  - dm_rd is captured.
  - Byte/half of req_wdata is merged into the addressed lane; other lanes are kept.
  - Next state: WRITE.
- WRITE (1 cycle): dm_we=1, dm_wd = merged word (word store: req_wdata verbatim); DM commits at the ending edge. Next state: RESP.
- RESP (1 cycle): rsp_valid=1, rsp_rdata/rsp_err held; next IDLE. rsp_rdata/rsp_err return to 0 in IDLE.
- Latency from accept edge to rsp_valid cycle:
  - error: 1
  - load/word store: 2
  - sub-word store: 3
- Throughput: no request is accepted while busy; req_valid held with ready=0 is not lost (the requester holds it).
- req_* changes after acceptance have no effect.

Decomposition:
- dm_pkg: size encodings, state enum, DM_WORDS default, lane-index helpers.
- One combinational sub-module, lsu_lane_align: merge (old word, data, size, addr[1:0]) -> new word; extract (word, size, signed, addr[1:0]) -> result.
- FSM, request register and DM drive stay in lsu_dm_master.

Test Plan:
1. Word store 0xFFFFFFFF to 0x28, pc 0x318 -> next cycle dm_we=1, dm_addr=0x28, dm_wd=0xFFFFFFFF, dm_pc=0x318; following cycle rsp_valid=1, rsp_err=0, rsp_rdata=0.
2. DM[0x28]=0x11223344; sb 0xA5 to 0x29 -> RMW_RD with dm_we=0, then WRITE with dm_wd=0x1122A544; rsp after 3 cycles.
3. DM[0x28]=0x80011234:
   - lh signed @0x2A -> rsp_rdata=0xFFFF8001.
   - lbu @0x2B -> rsp_rdata=0x00000080.
   - lw @0x28 -> 0x80011234.
4. lw @0x2A, sh @0x29, size=11, lw @0x1000 (DM_WORDS=1024) -> each rsp_valid one cycle after accept with rsp_err=1, rsp_rdata=0; dm_we never 1.
5. sb accepted, reset driven low during RMW_RD -> dm_we stays 0, DM unchanged, all outputs 0 immediately. After release, req_ready=1 and a new lw completes normally.
6. Back-to-back: req_valid held high across 3 loads -> req_ready=1 only in IDLE; exactly 3 rsp_valid pulses, in order, with correct data.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the load/store unit driving the word-wide data memory.
package dm_pkg;

  localparam int unsigned DM_WORDS_DEF = 1024;
  localparam int unsigned XLEN         = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Bit offset of the addressed byte / half inside a little-endian word.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic [1:0] off);
    return {off[1], 4'b0000};
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane merge for sub-word stores and lane extraction with sign/zero extension for loads.
module lsu_lane_align
  import dm_pkg::*;
(
  input  logic [XLEN-1:0] old_word_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] merged_c_o,
  output logic [XLEN-1:0] result_c_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    bsh        = byte_shift(offset_i);
    hsh        = half_shift(offset_i);
    lane_b     = 8'(old_word_i >> bsh);
    lane_h     = 16'(old_word_i >> hsh);
    merged_c_o = data_i;
    result_c_o = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        merged_c_o = (old_word_i & ~(32'h0000_00FF << bsh)) | (32'(data_i[7:0]) << bsh);
        result_c_o = signed_i ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      end
      SZ_HALF: begin
        merged_c_o = (old_word_i & ~(32'h0000_FFFF << hsh)) | (32'(data_i[15:0]) << hsh);
        result_c_o = signed_i ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      end
      default: begin
        merged_c_o = data_i;
        result_c_o = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dm_master.sv
// Load/store initiator for the data memory: one request at a time, RMW for sub-word stores.
module lsu_dm_master
  import dm_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [1:0]  size_q;
  logic        signed_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wd_q;
  logic        dm_we_q;
  logic [31:0] dm_pc_q;

  logic        req_err_c;
  logic [31:0] merged_c;
  logic [31:0] result_c;

  // Request legality is judged on the live inputs so the error path needs no extra cycle.
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = |req_addr[1:0];
      SZ_ILL:  req_err_c = 1'b1;
      default: req_err_c = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err_c = 1'b1;
  end

  lsu_lane_align u_align (
    .old_word_i (dm_rd),
    .data_i     (wdata_q),
    .size_i     (size_q),
    .signed_i   (signed_q),
    .offset_i   (addr_q[1:0]),
    .merged_c_o (merged_c),
    .result_c_o (result_c)
  );

  // Outputs are computed for the state being entered, so every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      dm_addr_q   <= '0;
      dm_wd_q     <= '0;
      dm_we_q     <= 1'b0;
      dm_pc_q     <= '0;
    end else begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wd_q     <= '0;
      dm_pc_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            pc_q        <= req_pc;
            size_q      <= req_size;
            signed_q    <= req_signed;
            if (req_err_c) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q   <= ST_LOAD;
              dm_addr_q <= word_align(req_addr);
            end else if (req_size == SZ_WORD) begin
              state_q   <= ST_WRITE;
              dm_addr_q <= word_align(req_addr);
              dm_wd_q   <= req_wdata;
              dm_we_q   <= 1'b1;
              dm_pc_q   <= req_pc;
            end else begin
              state_q   <= ST_RMW_RD;
              dm_addr_q <= word_align(req_addr);
            end
          end
        end
        ST_LOAD: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= result_c;
        end
        ST_RMW_RD: begin
          state_q   <= ST_WRITE;
          dm_addr_q <= word_align(addr_q);
          dm_wd_q   <= merged_c;
          dm_we_q   <= 1'b1;
          dm_pc_q   <= pc_q;
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wd     = dm_wd_q;
  assign dm_we     = dm_we_q;
  assign dm_pc     = dm_pc_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
// Scoreboard bench for lsu_dm_master with a behavioural word-wide data memory.
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] mem [0:1023];
  bit          we_seen;

  always #5 clk = ~clk;

  lsu_dm_master #(.DM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_addr    (dm_addr),
    .dm_wd      (dm_wd),
    .dm_we      (dm_we),
    .dm_pc      (dm_pc),
    .dm_rd      (dm_rd)
  );

  // Behavioural DM: combinational read, write committed on the rising edge.
  assign dm_rd = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (dm_we === 1'b1) begin
      mem[dm_addr[11:2]] <= dm_wd;
      we_seen = 1'b1;
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                      output bit acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = pc;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_pc     = $urandom;
  endtask

  task automatic await_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = 'x; er = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, dm_we, rsp_rdata, dm_addr, dm_wd, dm_pc} !== '0)
      $display("FAIL reset_outputs: got ready=%b rsp=%b err=%b we=%b rdata=%h addr=%h wd=%h pc=%h, want all 0",
               req_ready, rsp_valid, rsp_err, dm_we, rsp_rdata, dm_addr, dm_wd, dm_pc);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
    else passes++;
  endtask

  task automatic test_word_store;
    bit acc; exp_t e;
    send(1'b1, 2'b10, 1'b0, 32'h28, 32'hFFFF_FFFF, 32'h318, acc);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    checks++;
    if (!acc) $display("FAIL sw_accept: not accepted within bound");
    else passes++;
    @(negedge clk);
    checks++;
    if ({dm_we, dm_addr, dm_wd, dm_pc, rsp_valid} !== {1'b1, 32'h28, 32'hFFFF_FFFF, 32'h318, 1'b0})
      $display("FAIL sw_write_cycle: got we=%b addr=%h wd=%h pc=%h rsp=%b want we=1 addr=28 wd=ffffffff pc=318 rsp=0",
               dm_we, dm_addr, dm_wd, dm_pc, rsp_valid);
    else passes++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, dm_we} !== {1'b1, e.err, e.rdata, 1'b0})
      $display("FAIL sw_resp: got valid=%b err=%b rdata=%h we=%b want valid=1 err=%b rdata=%h we=0",
               rsp_valid, rsp_err, rsp_rdata, dm_we, e.err, e.rdata);
    else passes++;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, mem[10]} !== {1'b0, 1'b1, 32'hFFFF_FFFF})
      $display("FAIL sw_after: got valid=%b ready=%b mem=%h want valid=0 ready=1 mem=ffffffff",
               rsp_valid, req_ready, mem[10]);
    else passes++;
  endtask

  task automatic test_byte_store;
    bit acc; int lat; logic [31:0] rd; logic er; exp_t e;
    mem[10] = 32'h1122_3344;
    send(1'b1, 2'b00, 1'b0, 32'h29, 32'hDEAD_BEA5, 32'h400, acc);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
    @(negedge clk);
    checks++;
    if ({dm_we, dm_addr} !== {1'b0, 32'h28})
      $display("FAIL sb_rmw_rd: got we=%b addr=%h want we=0 addr=28", dm_we, dm_addr);
    else passes++;
    @(negedge clk);
    checks++;
    if ({dm_we, dm_addr, dm_wd, dm_pc} !== {1'b1, 32'h28, 32'h1122_A544, 32'h400})
      $display("FAIL sb_write: got we=%b addr=%h wd=%h pc=%h want we=1 addr=28 wd=1122a544 pc=400",
               dm_we, dm_addr, dm_wd, dm_pc);
    else passes++;
    await_rsp(lat, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (lat + 2 !== e.lat || rd !== e.rdata || er !== e.err)
      $display("FAIL sb_resp: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
               lat + 2, rd, er, e.lat, e.rdata, e.err);
    else passes++;
    checks++;
    if (mem[10] !== 32'h1122_A544) $display("FAIL sb_mem: got %h want 1122a544", mem[10]);
    else passes++;
  endtask

  task automatic test_loads;
    logic [1:0]  sz [3] = '{2'b01, 2'b00, 2'b10};
    logic        sg [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ad [3] = '{32'h2A, 32'h2B, 32'h28};
    logic [31:0] ex [3] = '{32'hFFFF_8001, 32'h0000_0080, 32'h8001_1234};
    bit acc; int lat; logic [31:0] rd; logic er; exp_t e;
    mem[10] = 32'h8001_1234;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, sz[i], sg[i], ad[i], 32'h0, 32'h500, acc);
      exp_q.push_back('{rdata: ex[i], err: 1'b0, lat: 2});
      await_rsp(lat, rd, er);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err)
        $display("FAIL load_%0d: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                 i, lat, rd, er, e.lat, e.rdata, e.err);
      else passes++;
    end
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h2A, 32'h29, 32'h28, 32'h1000};
    bit acc; int lat; logic [31:0] rd; logic er; exp_t e;
    we_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(we[i], sz[i], 1'b0, ad[i], 32'h5555_5555, 32'h600, acc);
      exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      await_rsp(lat, rd, er);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err)
        $display("FAIL err_%0d: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                 i, lat, rd, er, e.lat, e.rdata, e.err);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (we_seen !== 1'b0) $display("FAIL err_no_write: got dm_we seen=%b want 0", we_seen);
    else passes++;
  endtask

  task automatic test_reset_abort;
    bit acc; int lat; logic [31:0] rd; logic er; exp_t e;
    mem[10] = 32'h1122_3344;
    we_seen = 1'b0;
    send(1'b1, 2'b00, 1'b0, 32'h28, 32'h0000_005A, 32'h700, acc);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, dm_we, rsp_rdata, dm_addr, dm_wd, dm_pc} !== '0)
      $display("FAIL abort_outputs: got ready=%b rsp=%b we=%b addr=%h wd=%h want all 0",
               req_ready, rsp_valid, dm_we, dm_addr, dm_wd);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({we_seen, mem[10]} !== {1'b0, 32'h1122_3344})
      $display("FAIL abort_mem: got we_seen=%b mem=%h want 0 11223344", we_seen, mem[10]);
    else passes++;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", req_ready);
    else passes++;
    send(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'h704, acc);
    exp_q.push_back('{rdata: 32'h1122_3344, err: 1'b0, lat: 2});
    await_rsp(lat, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err)
      $display("FAIL abort_reload: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
               lat, rd, er, e.lat, e.rdata, e.err);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz [3] = '{2'b00, 2'b01, 2'b10};
    logic        sg [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ad [3] = '{32'h08, 32'h06, 32'h0C};
    logic [31:0] ex [3] = '{32'hFFFF_FFF3, 32'h0000_CAFE, 32'h1234_5678};
    int issued; int rsps; int bad_ready; bit prev_acc; exp_t e;
    mem[1] = 32'hCAFE_F00D; mem[2] = 32'h0000_00F3; mem[3] = 32'h1234_5678;
    issued = 0; rsps = 0; bad_ready = 0; prev_acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_pc = 32'h800;
    for (int c = 0; c < 30; c++) begin
      if (issued < 3) begin
        req_addr = ad[issued]; req_size = sz[issued]; req_signed = sg[issued];
      end else begin
        req_valid = 1'b0;
      end
      if (req_ready === 1'b1 && (rsp_valid === 1'b1 || prev_acc)) bad_ready++;
      if (rsp_valid === 1'b1) begin
        rsps++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL b2b_extra_rsp: got rsp with empty scoreboard, want none");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rsp_rdata !== e.rdata || rsp_err !== e.err)
            $display("FAIL b2b_rsp_%0d: got rdata=%h err=%b want rdata=%h err=%b",
                     rsps, rsp_rdata, rsp_err, e.rdata, e.err);
          else passes++;
        end
      end
      prev_acc = 1'b0;
      if (req_ready === 1'b1 && req_valid === 1'b1) begin
        exp_q.push_back('{rdata: ex[issued], err: 1'b0, lat: 2});
        issued++;
        prev_acc = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (rsps !== 3 || issued !== 3 || exp_q.size() != 0)
      $display("FAIL b2b_count: got rsps=%0d issued=%0d pending=%0d want 3 3 0", rsps, issued, exp_q.size());
    else passes++;
    checks++;
    if (bad_ready !== 0) $display("FAIL b2b_ready_busy: got %0d busy-ready cycles want 0", bad_ready);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    we_seen = 1'b0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_loads();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
